// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit: funct3 opcodes,
// control states and the iteration-counter width helper.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } muldiv_state_e;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/muldiv_special.sv
// Divide-by-zero and signed-overflow detection with the RISC-V mandated
// results; these cases bypass the iterative divider.
module muldiv_special
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  muldiv_op_e            op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  special,
   output logic [DATA_WIDTH-1:0] result
);

   localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic div_zero;
   logic ovf;
   logic quot_op;

   always_comb begin
      quot_op  = (op == OP_DIV) || (op == OP_DIVU);
      div_zero = op[2] && (b == '0);
      ovf      = ((op == OP_DIV) || (op == OP_REM)) && (a == MOST_NEG) && (b == '1);
      special  = div_zero || ovf;
      result   = '0;
      if (div_zero)
         result = quot_op ? '1 : a;
      else if (ovf)
         result = quot_op ? a : '0;
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiplier, restoring divider).
// Optional MULDIV_FAST_MUL_EN: multiplies finish in one CALC cycle via a combinational product.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [OPCODE_LENGTH-1:0] Operation,
   input  logic [DATA_WIDTH-1:0]    SrcA,
   input  logic [DATA_WIDTH-1:0]    SrcB,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    Result,
   output logic                     busy
);

   localparam int W     = DATA_WIDTH;
   localparam int CNT_W = cnt_width(DATA_WIDTH);

   muldiv_state_e    state, state_n;
   logic [CNT_W-1:0] cnt;
   logic             calc_done;
   logic             fast_mul;

   muldiv_op_e       op_in, op_q;
   logic             a_sgn, b_sgn;
   logic [W-1:0]     mag_a, mag_b;
   logic             special;
   logic [W-1:0]     special_res;

   logic             neg_q, rneg_q, spec_q;
   logic [W-1:0]     spec_res_q;
   logic [W-1:0]     opnd_q;
   logic [2*W-1:0]   p_q, p_step;
   logic [W-1:0]     final_res;

   // One multiply (shift-add) or divide (restoring) step on the shared product register
   function automatic logic [2*W-1:0] iter_step(input logic is_div,
                                                input logic [2*W-1:0] p,
                                                input logic [W-1:0] d);
      logic [W:0] sum;
      logic [W:0] shifted;
      logic [W:0] diff;
      sum     = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, d} : '0);
      shifted = {p[2*W-1:W], p[W-1]};
      diff    = shifted - {1'b0, d};
      if (!is_div)
         return {sum, p[W-1:1]};
      else if (diff[W])
         return {shifted[W-1:0], p[W-2:0], 1'b0};
      else
         return {diff[W-1:0], p[W-2:0], 1'b1};
   endfunction

   // Sign application and half selection on the final magnitude result
   function automatic logic [W-1:0] finish(input muldiv_op_e op,
                                           input logic [2*W-1:0] p,
                                           input logic neg,
                                           input logic rneg);
      logic [2*W-1:0] prod;
      logic [W-1:0]   q;
      logic [W-1:0]   r;
      prod = neg  ? -p : p;
      q    = neg  ? -p[W-1:0] : p[W-1:0];
      r    = rneg ? -p[2*W-1:W] : p[2*W-1:W];
      case (op)
         OP_MUL:                       return prod[W-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: return prod[2*W-1:W];
         OP_DIV, OP_DIVU:              return q;
         default:                      return r;
      endcase
   endfunction

   always_comb begin
      op_in = muldiv_op_e'(Operation);
      a_sgn = SrcA[W-1] && (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
      b_sgn = SrcB[W-1] && (op_in inside {OP_MULH, OP_DIV, OP_REM});
      mag_a = a_sgn ? -SrcA : SrcA;
      mag_b = b_sgn ? -SrcB : SrcB;
   end

   muldiv_special #(.DATA_WIDTH(W)) u_special (
      .op      (op_in),
      .a       (SrcA),
      .b       (SrcB),
      .special (special),
      .result  (special_res)
   );

`ifdef MULDIV_FAST_MUL_EN
   logic [2*W-1:0] p_fast;
   assign p_fast   = {{W{1'b0}}, opnd_q} * {{W{1'b0}}, p_q[W-1:0]};
   assign fast_mul = ~op_q[2];
`else
   assign fast_mul = 1'b0;
`endif

   always_comb begin
      p_step = iter_step(op_q[2], p_q, opnd_q);
      if (spec_q)
         final_res = spec_res_q;
`ifdef MULDIV_FAST_MUL_EN
      else if (fast_mul)
         final_res = finish(op_q, p_fast, neg_q, rneg_q);
`endif
      else
         final_res = finish(op_q, p_step, neg_q, rneg_q);
   end

   always_comb begin
      state_n   = state;
      calc_done = 1'b0;
      case (state)
         IDLE: if (in_valid) state_n = CALC;
         CALC: begin
            calc_done = spec_q || fast_mul || (cnt == CNT_W'(W - 1));
            if (calc_done) state_n = DONE;
         end
         DONE: if (out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         Result <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE)
            cnt <= '0;
         else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            if (calc_done) Result <= final_res;
         end
      end
   end

   // Operand capture on acceptance, then one iteration per CALC cycle
   always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
         op_q       <= op_in;
         neg_q      <= a_sgn ^ b_sgn;
         rneg_q     <= a_sgn;
         spec_q     <= special;
         spec_res_q <= special_res;
         opnd_q     <= op_in[2] ? mag_b : mag_a;
         p_q        <= {{W{1'b0}}, (op_in[2] ? mag_a : mag_b)};
      end else if (state == CALC) begin
         p_q <= p_step;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors, randomized ops
// against an arithmetic reference model, backpressure and mid-op reset.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  Operation;
   logic [31:0] SrcA, SrcB;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] Result;
   logic        busy;

   int errors = 0;
   int checks = 0;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 32;
`endif

   always #5 clk = ~clk;

   muldiv_unit #(.DATA_WIDTH(32), .OPCODE_LENGTH(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Operation (Operation),
      .SrcA      (SrcA),
      .SrcB      (SrcB),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Result    (Result),
      .busy      (busy)
   );

   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] prod;
      logic ovf;
      sa = $signed(a);
      sb = $signed(b);
      ua = a;
      ub = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         3'd0: begin prod = ua * ub; return prod[31:0]; end
         3'd1: begin prod = sa * sb; return prod[63:32]; end
         3'd2: begin prod = sa * ub; return prod[63:32]; end
         3'd3: begin prod = {32'b0, a} * {32'b0, b}; return prod[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return a;
            prod = sa / sb; return prod[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'h0;
            prod = sa % sb; return prod[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op[2] && (b == 0)) return 1;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return op[2] ? 32 : MUL_LAT;
   endfunction

   task automatic issue_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; SrcA = $urandom; SrcB = $urandom; Operation = 3'($urandom);
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic take_result();
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
   endtask

   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
      issue_op(op, a, b);
      wait_out(lat);
      res = Result;
      take_result();
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      Operation = '0; SrcA = '0; SrcB = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (Result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h want=0", Result); end
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_directed();
      logic [2:0]  ops [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
      logic [31:0] as  [12] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
      logic [31:0] bs  [12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2,
                                32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] exp [12] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
      int          lats[12] = '{MUL_LAT, MUL_LAT, MUL_LAT, MUL_LAT, 32, 32, 32, 32, 1, 1, 1, 1};
      logic [31:0] res;
      int          lat;
      for (int i = 0; i < 12; i++) begin
         do_op(ops[i], as[i], bs[i], res, lat);
         checks++;
         if (res !== exp[i]) begin
            errors++; $display("FAIL directed_result[%0d] op=%0d got=%h want=%h", i, ops[i], res, exp[i]);
         end
         checks++;
         if (lat != lats[i]) begin
            errors++; $display("FAIL directed_latency[%0d] op=%0d got=%0d want=%0d", i, ops[i], lat, lats[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] a, b, res, exp;
      int          lat, elat;
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 20));
            3: b = -32'($urandom_range(1, 20));
            default: ;
         endcase
         exp  = model(op, a, b);
         elat = model_lat(op, a, b);
         do_op(op, a, b, res, lat);
         checks++;
         if (res !== exp) begin
            errors++; $display("FAIL random_result op=%0d a=%h b=%h got=%h want=%h", op, a, b, res, exp);
         end
         checks++;
         if (lat != elat) begin
            errors++; $display("FAIL random_latency op=%0d a=%h b=%h got=%0d want=%0d", op, a, b, lat, elat);
         end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      issue_op(3'd5, 32'd100, 32'd7);
      wait_out(lat);
      checks++;
      if (Result !== 32'd14) begin errors++; $display("FAIL bp_initial_result got=%h want=%h", Result, 32'd14); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1; Operation = 3'd0; SrcA = $urandom; SrcB = $urandom;
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold[%0d] out_valid=%b in_ready=%b want 1/0", i, out_valid, in_ready);
         end
         checks++;
         if (Result !== 32'd14) begin errors++; $display("FAIL bp_result[%0d] got=%h want=%h", i, Result, 32'd14); end
      end
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_release in_ready=%b busy=%b out_valid=%b want 1/0/0", in_ready, busy, out_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] res;
      int          lat;
      bit          seen;
      issue_op(3'd4, 32'd1000, 32'd3);
      repeat (9) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL midreset_state in_ready=%b busy=%b want 1/0", in_ready, busy);
      end
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL midreset_no_valid got=1 want=0"); end
      do_op(3'd0, 32'd3, 32'd4, res, lat);
      checks++;
      if (res !== 32'd12) begin errors++; $display("FAIL midreset_mul got=%h want=%h", res, 32'd12); end
      checks++;
      if (lat != MUL_LAT) begin errors++; $display("FAIL midreset_mul_latency got=%0d want=%0d", lat, MUL_LAT); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout reached without completion");
      $fatal(1, "timeout");
   end

endmodule
